pst_stack: RTL and testbench

//  Parametrised N-layer predictive-coding phase stack. Successor to the fixed 2-layer PST.

---
 rtl/pst_pkg.sv | 29 ++
 rtl/pst_layer_update.sv | 49 ++++
 rtl/pst_stack.sv | 172 +++++++++++++++++
 tb/tb_pst_stack.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pst_pkg.sv
// Shared types and helpers for the predictive-coding phase stack.
package pst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } pst_state_e;

  localparam int unsigned WEIGHT_W = 8;

  // Layer-index width; a single-layer stack still needs one bit.
  function automatic int unsigned pstk_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [WEIGHT_W-1:0] sat_add(input logic [WEIGHT_W-1:0] a,
                                                  input logic [WEIGHT_W-1:0] b);
    logic [WEIGHT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WEIGHT_W] ? {WEIGHT_W{1'b1}} : s[WEIGHT_W-1:0];
  endfunction

  function automatic logic [WEIGHT_W-1:0] sat_sub(input logic [WEIGHT_W-1:0] a,
                                                  input logic [WEIGHT_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/pst_layer_update.sv
// Combinational single-layer update: error, weighted step toward target,
// optional top-down blend and confidence-weight adaptation.
module pst_layer_update
  import pst_pkg::*;
#(
  parameter int unsigned PHASE_W  = 8,
  parameter int unsigned ETA_LTP  = 4,
  parameter int unsigned ETA_LTD  = 3,
  parameter int unsigned TOL      = 1,
  parameter int unsigned TD_SHIFT = 2
) (
  input  logic [PHASE_W-1:0]  tgt,
  input  logic [PHASE_W-1:0]  pred,
  input  logic [WEIGHT_W-1:0] weight,
  input  logic [PHASE_W-1:0]  td,
  input  logic                td_en,
  output logic [PHASE_W-1:0]  pred_nxt_c,
  output logic [PHASE_W-1:0]  err_c,
  output logic                sign_c,
  output logic [WEIGHT_W-1:0] weight_nxt_c
);

  localparam int unsigned PROD_W = PHASE_W + WEIGHT_W;

  logic [PROD_W-1:0]         prod;
  logic [PHASE_W-1:0]        step;
  logic [PHASE_W-1:0]        pn;
  logic signed [PHASE_W:0]   diff;
  logic signed [PHASE_W:0]   blend;

  always_comb begin
    sign_c = (tgt > pred);
    err_c  = sign_c ? (tgt - pred) : (pred - tgt);
    prod   = PROD_W'(err_c) * PROD_W'(weight);
    step   = PHASE_W'(prod >> WEIGHT_W);
    // Guarantee progress on any nonzero error, and never step past the target.
    if ((step == '0) && (err_c != '0)) step = PHASE_W'(1);
    if (step > err_c) step = err_c;
    pn     = sign_c ? (pred + step) : (pred - step);

    diff   = $signed({1'b0, td}) - $signed({1'b0, pn});
    blend  = $signed({1'b0, pn}) + (diff >>> TD_SHIFT);
    pred_nxt_c = td_en ? blend[PHASE_W-1:0] : pn;

    weight_nxt_c = (err_c <= PHASE_W'(TOL)) ? sat_add(weight, WEIGHT_W'(ETA_LTP))
                                            : sat_sub(weight, WEIGHT_W'(ETA_LTD));
  end

endmodule

// File: rtl/pst_stack.sv
// N-layer predictive-coding phase stack, one layer per clock through a shared datapath.
// Optional top-down blending of non-top layers when PST_TOPDOWN_EN is defined.
module pst_stack
  import pst_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned PHASE_W    = 8,
  parameter int unsigned PRED_INIT  = 128,
  parameter int unsigned W_INIT     = 128,
  parameter int unsigned ETA_LTP    = 4,
  parameter int unsigned ETA_LTD    = 3,
  parameter int unsigned TOL        = 1,
  parameter int unsigned TD_SHIFT   = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cycle_start,
  input  logic [PHASE_W-1:0]               phase_in,
  input  logic                             fired_in,
  output logic [NUM_LAYERS*PHASE_W-1:0]    pred_flat,
  output logic [NUM_LAYERS*PHASE_W-1:0]    err_flat,
  output logic [NUM_LAYERS-1:0]            err_sign,
  output logic [NUM_LAYERS*WEIGHT_W-1:0]   weight_flat,
  output logic                             err_valid0,
  output logic                             busy,
  output logic                             sweep_done,
  output logic [7:0]                       overrun_cnt
);

  localparam int unsigned PSTK_W = pstk_w(NUM_LAYERS);

  pst_state_e state_q, state_d;

  logic [PHASE_W-1:0]  pred_q   [NUM_LAYERS];
  logic [PHASE_W-1:0]  snap_q   [NUM_LAYERS];
  logic [PHASE_W-1:0]  err_q    [NUM_LAYERS];
  logic [WEIGHT_W-1:0] weight_q [NUM_LAYERS];
  logic [PSTK_W-1:0]   k_q;

  logic                win_fired_q, eval_fired_q;
  logic [PHASE_W-1:0]  win_phase_q, eval_phase_q;

  logic start, step_en, finish, overrun, k_last;
  logic [PSTK_W-1:0]   lo_idx, hi_idx;
  logic [PHASE_W-1:0]  tgt, td;
  logic                td_en;
  logic [PHASE_W-1:0]  pred_nxt, err_nxt;
  logic                sign_nxt;
  logic [WEIGHT_W-1:0] weight_nxt;

  // Next-state and sweep control.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    step_en = 1'b0;
    finish  = 1'b0;
    k_last  = (k_q == PSTK_W'(NUM_LAYERS - 1));
    overrun = cycle_start && (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (cycle_start) begin
          start   = 1'b1;
          state_d = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        step_en = 1'b1;
        if (k_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        finish  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand selection for the shared datapath.
  always_comb begin
    lo_idx = (k_q == '0) ? '0 : (k_q - PSTK_W'(1));
    hi_idx = k_last ? k_q : (k_q + PSTK_W'(1));
    tgt    = (k_q == '0) ? eval_phase_q : snap_q[lo_idx];
    td     = snap_q[hi_idx];
`ifdef PST_TOPDOWN_EN
    td_en  = !k_last;
`else
    td_en  = 1'b0;
`endif
  end

  pst_layer_update #(
    .PHASE_W  (PHASE_W),
    .ETA_LTP  (ETA_LTP),
    .ETA_LTD  (ETA_LTD),
    .TOL      (TOL),
    .TD_SHIFT (TD_SHIFT)
  ) u_layer (
    .tgt          (tgt),
    .pred         (pred_q[k_q]),
    .weight       (weight_q[k_q]),
    .td           (td),
    .td_en        (td_en),
    .pred_nxt_c   (pred_nxt),
    .err_c        (err_nxt),
    .sign_c       (sign_nxt),
    .weight_nxt_c (weight_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      win_fired_q  <= 1'b0;
      win_phase_q  <= '0;
      eval_fired_q <= 1'b0;
      eval_phase_q <= '0;
      err_sign     <= '0;
      err_valid0   <= 1'b0;
      busy         <= 1'b0;
      sweep_done   <= 1'b0;
      overrun_cnt  <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        pred_q[i]   <= PHASE_W'(PRED_INIT);
        snap_q[i]   <= PHASE_W'(PRED_INIT);
        err_q[i]    <= '0;
        weight_q[i] <= WEIGHT_W'(W_INIT);
      end
    end else begin
      state_q    <= state_d;
      sweep_done <= finish;
      if (finish) busy <= 1'b0;
      if (overrun && (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;

      // A fire coinciding with an accepted start opens the new window.
      if (start) begin
        eval_fired_q <= win_fired_q;
        eval_phase_q <= win_phase_q;
        win_fired_q  <= fired_in;
        if (fired_in) win_phase_q <= phase_in;
        k_q  <= '0;
        busy <= 1'b1;
        for (int i = 0; i < NUM_LAYERS; i++) snap_q[i] <= pred_q[i];
      end else if (fired_in && !win_fired_q) begin
        win_fired_q <= 1'b1;
        win_phase_q <= phase_in;
      end

      if (step_en) begin
        if ((k_q == '0) && !eval_fired_q) begin
          err_q[0]    <= '0;
          err_sign[0] <= 1'b0;
          err_valid0  <= 1'b0;
          weight_q[0] <= sat_sub(weight_q[0], WEIGHT_W'(ETA_LTD));
        end else begin
          pred_q[k_q]   <= pred_nxt;
          err_q[k_q]    <= err_nxt;
          err_sign[k_q] <= sign_nxt;
          weight_q[k_q] <= weight_nxt;
          if (k_q == '0) err_valid0 <= 1'b1;
        end
        if (!k_last) k_q <= k_q + PSTK_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_flat
    assign pred_flat[i*PHASE_W +: PHASE_W]     = pred_q[i];
    assign err_flat[i*PHASE_W +: PHASE_W]      = err_q[i];
    assign weight_flat[i*WEIGHT_W +: WEIGHT_W] = weight_q[i];
  end

endmodule

// File: tb/tb_pst_stack.sv
// Directed self-checking bench for pst_stack (default build, 4 layers, 8-bit phase).
module tb_pst_stack;

  localparam int NL = 4;
  localparam int PW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cycle_start;
  logic [PW-1:0]   phase_in;
  logic            fired_in;
  logic [NL*PW-1:0] pred_flat;
  logic [NL*PW-1:0] err_flat;
  logic [NL-1:0]   err_sign;
  logic [NL*8-1:0] weight_flat;
  logic            err_valid0;
  logic            busy;
  logic            sweep_done;
  logic [7:0]      overrun_cnt;

  int n_vec = 0;
  int n_err = 0;

  pst_stack dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cycle_start (cycle_start),
    .phase_in    (phase_in),
    .fired_in    (fired_in),
    .pred_flat   (pred_flat),
    .err_flat    (err_flat),
    .err_sign    (err_sign),
    .weight_flat (weight_flat),
    .err_valid0  (err_valid0),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk = ~clk;

  function automatic int pr(input int k);
    return int'(pred_flat[k*PW +: PW]);
  endfunction
  function automatic int er(input int k);
    return int'(err_flat[k*PW +: PW]);
  endfunction
  function automatic int wt(input int k);
    return int'(weight_flat[k*8 +: 8]);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Optional fire, then a start pulse; extra_at re-pulses cycle_start n clocks into the sweep.
  task automatic run_sweep(input logic fire, input logic [PW-1:0] ph, input int extra_at,
                           output int lat);
    if (fire) begin
      fired_in = 1'b1;
      phase_in = ph;
      tick();
      fired_in = 1'b0;
    end
    cycle_start = 1'b1;
    tick();
    cycle_start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      if (n - 1 == extra_at) cycle_start = 1'b1;
      tick();
      cycle_start = 1'b0;
      if (sweep_done) begin
        lat = n;
        break;
      end
    end
    chk("sweep_latency", lat, NL + 1);
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (sweep_done) pulses++;
    end
  endtask

  int lat;
  int pulses;
  int conv [NL];

  initial begin
    rst_n = 1'b0;
    cycle_start = 1'b0;
    phase_in = '0;
    fired_in = 1'b0;
    tick();
    tick();
    chk("rst_pred0", pr(0), 128);
    chk("rst_pred3", pr(3), 128);
    chk("rst_w0", wt(0), 128);
    chk("rst_err0", er(0), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(sweep_done), 0);
    chk("rst_ovr", int'(overrun_cnt), 0);
    chk("rst_valid0", int'(err_valid0), 0);
    rst_n = 1'b1;

    // Single fire at phase 4
    run_sweep(1'b1, 8'd4, -1, lat);
    chk("t1_pred0", pr(0), 66);
    chk("t1_err0", er(0), 124);
    chk("t1_sign0", int'(err_sign[0]), 0);
    chk("t1_w0", wt(0), 125);
    chk("t1_valid0", int'(err_valid0), 1);
    chk("t1_pred1", pr(1), 128);
    chk("t1_err1", er(1), 0);
    chk("t1_w1", wt(1), 132);
    chk("t1_w3", wt(3), 132);
    chk("t1_busy", int'(busy), 0);
    tick();
    chk("t1_done_pulse", int'(sweep_done), 0);

    // Constant phase 4: layer 0 lands on 4 after ten windows, weights saturate
    do_reset();
    for (int k = 0; k < NL; k++) conv[k] = 999;
    for (int w = 1; w <= 64; w++) begin
      run_sweep(1'b1, 8'd4, -1, lat);
      for (int k = 0; k < NL; k++)
        if (conv[k] == 999 && pr(k) == 4) conv[k] = w;
    end
    chk("t3_conv0", conv[0], 10);
    chk("t3_order1", int'(conv[1] >= conv[0]), 1);
    chk("t3_order2", int'(conv[2] >= conv[1]), 1);
    chk("t3_order3", int'(conv[3] >= conv[2]), 1);
    chk("t3_pred0", pr(0), 4);
    chk("t3_err0", er(0), 0);
    chk("t3_w0", wt(0), 255);

    // No fire: layer 0 held, weight decays and clamps at zero
    do_reset();
    for (int w = 0; w < 3; w++) run_sweep(1'b0, 8'd0, -1, lat);
    chk("t4_pred0", pr(0), 128);
    chk("t4_valid0", int'(err_valid0), 0);
    chk("t4_err0", er(0), 0);
    chk("t4_w0", wt(0), 119);
    for (int w = 0; w < 42; w++) run_sweep(1'b0, 8'd0, -1, lat);
    chk("t4_w0_clamp", wt(0), 0);
    chk("t4_w1_sat", wt(1), 255);

    // Overrun: second start two clocks into the sweep is counted and dropped
    do_reset();
    run_sweep(1'b1, 8'd4, 1, lat);
    chk("t5_ovr", int'(overrun_cnt), 1);
    count_done(12, pulses);
    chk("t5_no_second", pulses, 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_pred0", pr(0), 66);

    // Reset mid-sweep aborts it
    do_reset();
    fired_in = 1'b1;
    phase_in = 8'd4;
    tick();
    fired_in = 1'b0;
    cycle_start = 1'b1;
    tick();
    cycle_start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_pred0", pr(0), 128);
    chk("t6_w0", wt(0), 128);
    chk("t6_busy", int'(busy), 0);
    chk("t6_valid0", int'(err_valid0), 0);
    count_done(10, pulses);
    chk("t6_no_done", pulses, 0);

    // Fire together with start belongs to the following window
    fired_in = 1'b1;
    phase_in = 8'd4;
    cycle_start = 1'b1;
    tick();
    fired_in = 1'b0;
    cycle_start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (sweep_done) begin
        lat = n;
        break;
      end
    end
    chk("t6b_latency", lat, NL + 1);
    chk("t6b_valid0", int'(err_valid0), 0);
    chk("t6b_pred0", pr(0), 128);
    chk("t6b_w0", wt(0), 125);
    run_sweep(1'b0, 8'd0, -1, lat);
    chk("t6c_valid0", int'(err_valid0), 1);
    chk("t6c_pred0", pr(0), 68);
    chk("t6c_w0", wt(0), 122);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
